wb_write_arbiter: RTL and testbench

//  Shares the single integer register-file write port between two sources.
//  - Source 1: in-order writeback from the MEM/WB pipeline register.
//  - Source 2: out-of-order late load returns from the data-memory interface.

---
 rtl/wb_write_arbiter_pkg.sv | 23 ++
 rtl/wb_write_arbiter_if.sv | 31 +++
 rtl/wb_write_arbiter_ret_fifo.sv | 69 ++++++
 rtl/wb_write_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    wb_req_t req;
    logic    live;
  } wb_ent_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_QUEUE
  } grant_e;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the pipeline/memory side and the write arbiter.
interface wb_arb_if #(
  parameter int DEPTH = 4
);
  import wb_arb_pkg::*;

  logic                       pipe_we_i;
  logic [ADDR_W-1:0]          pipe_rd_i;
  logic [DATA_W-1:0]          pipe_data_i;
  logic                       ld_valid_i;
  logic [ADDR_W-1:0]          ld_rd_i;
  logic [DATA_W-1:0]          ld_data_i;
  logic                       ld_ready_o;
  logic                       stall_o;
  logic                       rf_we_o;
  logic [ADDR_W-1:0]          rf_waddr_o;
  logic [DATA_W-1:0]          rf_wdata_o;
  logic [$clog2(DEPTH):0]     q_count_o;
  logic [(2**ADDR_W)-1:0]     busy_o;

  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_data_i, ld_valid_i, ld_rd_i, ld_data_i,
    output ld_ready_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, q_count_o, busy_o
  );

  modport master (
    output pipe_we_i, pipe_rd_i, pipe_data_i, ld_valid_i, ld_rd_i, ld_data_i,
    input  ld_ready_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, q_count_o, busy_o
  );

endinterface

// File: rtl/wb_write_arbiter_ret_fifo.sv
// Late-load return queue; entries stay visible so the parent can track and kill them.
module wb_ret_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  wb_ent_t                   push_ent_i,
  input  logic                      pop_i,
  input  logic [DEPTH-1:0]          kill_i,
  output logic [CW-1:0]             count_o,
  output wb_ent_t                   head_o,
  output wb_ent_t [DEPTH-1:0]       ents_o,
  output logic [DEPTH-1:0]          valid_o
);

  wb_ent_t [DEPTH-1:0] ents_q, ents_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  always_comb begin
    ents_d   = ents_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i[i]) ents_d[i].live = 1'b0;
    end
    // A push only ever lands in a free slot, so it cannot collide with a kill.
    if (push_i) begin
      ents_d[wr_ptr_q]  = push_ent_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ents_q   <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ents_q   <= ents_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = ents_q[rd_ptr_q];
  assign ents_o  = ents_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the RF write port between MEM/WB writeback and queued late load returns.
// WB_SCOREBOARD_EN enables the busy mask and WAW kill of queued loads by pipe writes.
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arb_if.slave     bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]      count;
  wb_ent_t            head;
  wb_ent_t            push_ent;
  logic [DEPTH-1:0]   kill;
  logic               full, empty, stall, ld_acc, push, pop;
  grant_e             gnt;
  logic [SW-1:0]      starve_q, starve_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic               live_in;
  logic [(2**ADDR_W)-1:0] busy;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign stall  = full | ((starve_q == SW'(STARVE_MAX)) & ~empty);
  assign ld_acc = bus.ld_valid_i & ~full;
  assign push   = ld_acc & (bus.ld_rd_i != '0);
  assign pop    = (gnt == GNT_QUEUE);

  always_comb begin
    gnt = GNT_NONE;
    if (stall)                                       gnt = GNT_QUEUE;
    else if (bus.pipe_we_i && bus.pipe_rd_i != '0)   gnt = GNT_PIPE;
    else if (!empty)                                 gnt = GNT_QUEUE;
  end

`ifdef WB_SCOREBOARD_EN
  wb_ent_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]    valid;

  assign live_in = ~((gnt == GNT_PIPE) && (bus.ld_rd_i == bus.pipe_rd_i));

  always_comb begin
    kill = '0;
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = (gnt == GNT_PIPE) && valid[i] && (ents[i].req.rd == bus.pipe_rd_i);
      if (valid[i] && ents[i].live) busy[ents[i].req.rd] = 1'b1;
    end
    if (push && live_in) busy[bus.ld_rd_i] = 1'b1;
  end
`else
  assign live_in = 1'b1;
  assign kill    = '0;
  assign busy    = '0;
`endif

  assign push_ent = '{req: '{rd: bus.ld_rd_i, data: bus.ld_data_i}, live: live_in};

  wb_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .kill_i     (kill),
    .count_o    (count),
    .head_o     (head),
`ifdef WB_SCOREBOARD_EN
    .ents_o     (ents),
    .valid_o    (valid)
`else
    .ents_o     (),
    .valid_o    ()
`endif
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    starve_d   = starve_q;
    case (gnt)
      GNT_PIPE: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.pipe_rd_i;
        rf_wdata_d = bus.pipe_data_i;
      end
      GNT_QUEUE: begin
        // Killed entries still pop to free the slot, but never reach the RF.
        if (head.live) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = head.req.rd;
          rf_wdata_d = head.req.data;
        end
      end
      default: ;
    endcase
    if (pop || empty)                        starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))    starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.ld_ready_o = ~full;
  assign bus.stall_o    = stall;
  assign bus.rf_we_o    = rf_we_q;
  assign bus.rf_waddr_o = rf_waddr_q;
  assign bus.rf_wdata_o = rf_wdata_q;
  assign bus.q_count_o  = count;
  assign bus.busy_o     = busy;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (both WB_SCOREBOARD_EN builds).
module tb_wb_write_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_arb_if #(.DEPTH(4)) bus ();

  wb_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_we_i   = 1'b0;
    bus.pipe_rd_i   = '0;
    bus.pipe_data_i = '0;
    bus.ld_valid_i  = 1'b0;
    bus.ld_rd_i     = '0;
    bus.ld_data_i   = '0;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, bus.rf_we_o, we);
    if (we) begin
      chk({tag, "_addr"}, bus.rf_waddr_o, a);
      chk({tag, "_data"}, bus.rf_wdata_o, d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    chk("rst_we", bus.rf_we_o, 0);
    chk("rst_addr", bus.rf_waddr_o, 0);
    chk("rst_data", bus.rf_wdata_o, 0);
    chk("rst_cnt", bus.q_count_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    #20 rst_n = 1'b1;
    step();
    chk("rel_ready", bus.ld_ready_o, 1);

    // 1: pipe only
    bus.pipe_we_i = 1; bus.pipe_rd_i = 5; bus.pipe_data_i = 32'hDEADBEEF;
    #1 chk("t1_stall", bus.stall_o, 0);
    step();
    bus.pipe_we_i = 0;
    chk_rf("t1", 1, 5, 32'hDEADBEEF);
    chk("t1_stall2", bus.stall_o, 0);
    step();
    chk("t1_idle_we", bus.rf_we_o, 0);

    // 2: load return with idle pipe, no bypass
    bus.ld_valid_i = 1; bus.ld_rd_i = 7; bus.ld_data_i = 32'h11;
    step();
    bus.ld_valid_i = 0;
    chk("t2_nobypass", bus.rf_we_o, 0);
    chk("t2_cnt1", bus.q_count_o, 1);
    step();
    chk_rf("t2", 1, 7, 32'h11);
    chk("t2_cnt0", bus.q_count_o, 0);

    // 3: starvation
    bus.ld_valid_i = 1; bus.ld_rd_i = 3; bus.ld_data_i = 32'h33;
    bus.pipe_we_i = 1; bus.pipe_rd_i = 4; bus.pipe_data_i = 32'h44;
    step();
    bus.ld_valid_i = 0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t3_nostall%0d", i), bus.stall_o, 0);
      chk($sformatf("t3_pipe%0d", i), bus.rf_waddr_o, 4);
      step();
    end
    chk("t3_stall", bus.stall_o, 1);
    chk("t3_cnt", bus.q_count_o, 1);
    step();
    chk_rf("t3_q", 1, 3, 32'h33);
    chk("t3_unstall", bus.stall_o, 0);
    step();
    chk_rf("t3_held", 1, 4, 32'h44);
    bus.pipe_we_i = 0;
    step();

    // 4: full queue with pipe busy
    bus.pipe_we_i = 1; bus.pipe_rd_i = 4; bus.pipe_data_i = 32'h55;
    bus.ld_valid_i = 1;
    for (int k = 0; k < 4; k++) begin
      bus.ld_rd_i = 5'(10 + k); bus.ld_data_i = 32'hA0 + k;
      step();
    end
    bus.ld_valid_i = 0; bus.pipe_we_i = 0;
    chk("t4_notready", bus.ld_ready_o, 0);
    chk("t4_stall", bus.stall_o, 1);
    chk("t4_cnt", bus.q_count_o, 4);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_rf($sformatf("t4_drain%0d", k), 1, 5'(10 + k), 32'hA0 + k);
    end
    chk("t4_cnt0", bus.q_count_o, 0);
    chk("t4_ready", bus.ld_ready_o, 1);
    step();

    // 5: writes to x0
    bus.pipe_we_i = 1; bus.pipe_rd_i = 0; bus.pipe_data_i = 32'hFF;
    bus.ld_valid_i = 1; bus.ld_rd_i = 0; bus.ld_data_i = 32'hEE;
    #1 chk("t5_ready", bus.ld_ready_o, 1);
    step();
    idle_inputs();
    chk("t5_we", bus.rf_we_o, 0);
    chk("t5_cnt", bus.q_count_o, 0);
    step();
    chk("t5_we2", bus.rf_we_o, 0);

    // 6: WAW between a queued load and a pipe write
    bus.ld_valid_i = 1; bus.ld_rd_i = 9; bus.ld_data_i = 32'h99;
    bus.pipe_we_i = 1; bus.pipe_rd_i = 4; bus.pipe_data_i = 32'h1;
    #1;
`ifdef WB_SCOREBOARD_EN
    chk("t6_busy_in", bus.busy_o[9], 1);
`else
    chk("t6_busy_in", bus.busy_o, 0);
`endif
    step();
    bus.ld_valid_i = 0;
    bus.pipe_rd_i = 9; bus.pipe_data_i = 32'h22;
    #1;
`ifdef WB_SCOREBOARD_EN
    chk("t6_busy_q", bus.busy_o[9], 1);
`else
    chk("t6_busy_q", bus.busy_o, 0);
`endif
    step();
    bus.pipe_we_i = 0;
    #1;
    chk_rf("t6_pipe", 1, 9, 32'h22);
    chk("t6_cnt", bus.q_count_o, 1);
    chk("t6_busy_clr", bus.busy_o, 0);
    step();
    chk("t6_cnt0", bus.q_count_o, 0);
`ifdef WB_SCOREBOARD_EN
    chk("t6_killed", bus.rf_we_o, 0);
`else
    chk_rf("t6_late", 1, 9, 32'h99);
`endif
    step();

    // async reset with entries queued
    bus.pipe_we_i = 1; bus.pipe_rd_i = 4; bus.pipe_data_i = 32'h66;
    bus.ld_valid_i = 1;
    for (int k = 0; k < 3; k++) begin
      bus.ld_rd_i = 5'(20 + k); bus.ld_data_i = 32'hC0 + k;
      step();
    end
    bus.ld_valid_i = 0;
    chk("rs_cnt3", bus.q_count_o, 3);
    chk("rs_we_pre", bus.rf_we_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_cnt", bus.q_count_o, 0);
    chk("rs_we", bus.rf_we_o, 0);
    chk("rs_addr", bus.rf_waddr_o, 0);
    chk("rs_data", bus.rf_wdata_o, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rs_ready", bus.ld_ready_o, 1);
    chk("rs_we_post", bus.rf_we_o, 0);
    chk("rs_cnt_post", bus.q_count_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
